// File: rtl/time_pkg.sv
// ---------------------------------------------------------------------------
// time_pkg
//   Shared types, limits and helpers for the time-of-day keeper.
//   - bcd2_t      : two-digit packed BCD value (high digit in [7:4]).
//   - SEC_MAX     : last second value before wrap (BCD 59).
//   - MIN_MAX     : last minute value before wrap (BCD 59).
//   - bcd_valid() : both digits 0..9 and value not above a BCD maximum.
//   - bcd_inc()   : per-digit BCD increment with low-to-high digit carry.
// ---------------------------------------------------------------------------
package time_pkg;

    typedef logic [7:0] bcd2_t;

    localparam bcd2_t SEC_MAX = 8'h59;
    localparam bcd2_t MIN_MAX = 8'h59;

    // For valid BCD, numeric compare of the packed byte matches decimal order.
    function automatic logic bcd_valid(bcd2_t v, bcd2_t max);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v <= max);
    endfunction

    function automatic bcd2_t bcd_inc(bcd2_t v);
        bcd2_t r;
        if (v[3:0] >= 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_mod_counter.sv
// ---------------------------------------------------------------------------
// bcd_mod_counter
//   One two-digit BCD field (seconds, minutes or hours) that counts 00..max
//   and wraps back to 00. Load has priority over increment.
// Ports
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset (value -> 00)
//   i_inc       in   advance the field by one
//   i_load      in   replace the field with i_load_val
//   i_load_val  in   BCD value to load (already validated by the caller)
//   i_max       in   BCD value after which the field wraps to 00
//   o_value     out  current field value
//   o_next      out  value the field takes at the next clock edge
//   o_wrap      out  combinational: i_inc while the field sits at i_max
// ---------------------------------------------------------------------------
module bcd_mod_counter
    import time_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic [7:0] i_max,
    output logic [7:0] o_value,
    output logic [7:0] o_next,
    output logic       o_wrap
);

    logic [7:0] r_value;
    logic [7:0] w_next;

    always_comb begin
        w_next = r_value;
        if (i_load) begin
            w_next = i_load_val;
        end else if (i_inc) begin
            w_next = (r_value == i_max) ? 8'h00 : bcd_inc(r_value);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= 8'h00;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;
    assign o_next  = w_next;
    assign o_wrap  = i_inc & (r_value == i_max);

endmodule

// File: rtl/time_counter.sv
// ---------------------------------------------------------------------------
// time_counter
//   BCD hh:mm:ss time-of-day keeper driven by the 1 Hz square wave from the
//   clock divider. The wave is synchronized into clk, its rising edges are
//   detected, and each accepted rise advances the time by one second.
//   Same-cycle priority: load > inc_min/inc_hour > tick; a losing tick is
//   dropped. A rejected load also swallows any same-cycle inc or tick.
// Configuration
//   HOURLY_CHIME_EN : when defined, chime is high while min==00 and
//                     sec < CHIME_LEN; otherwise chime is tied low.
// Parameters
//   SYNC_STAGES  synchronizer depth on tick_in (>= 2)
//   HOUR_MAX     BCD hour after which hours wrap to 00
//   CHIME_LEN    chime length in seconds (HOURLY_CHIME_EN only)
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   tick_in                     1 Hz square wave (asynchronous to clk)
//   run                         1: rises advance time, 0: rises discarded
//   load, set_hour/min/sec      one-cycle load of a BCD time
//   inc_min, inc_hour           one-cycle manual adjust pulses
//   hour_bcd, min_bcd, sec_bcd  current time, BCD
//   sec_pulse                   pulse on each tick-driven advance
//   day_wrap                    pulse on HOUR_MAX:59:59 -> 00:00:00 by tick
//   load_err                    pulse one cycle after a rejected load
//   chime                       hourly chime level
// ---------------------------------------------------------------------------
module time_counter
    import time_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] HOUR_MAX    = 8'h23,
    parameter int         CHIME_LEN   = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_in,
    input  logic       run,
    input  logic       load,
    input  logic [7:0] set_hour,
    input  logic [7:0] set_min,
    input  logic [7:0] set_sec,
    input  logic       inc_min,
    input  logic       inc_hour,
    output logic [7:0] hour_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       sec_pulse,
    output logic       day_wrap,
    output logic       load_err,
    output logic       chime
);

    localparam bcd2_t CHIME_BCD = bcd2_t'(((CHIME_LEN / 10) % 10) * 16 + (CHIME_LEN % 10));

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_hist;
    logic                   r_sec_pulse;
    logic                   r_day_wrap;
    logic                   r_load_err;

    logic       w_rise;
    logic       w_load_valid;
    logic       w_load_ok;
    logic       w_load_bad;
    logic       w_inc_min;
    logic       w_inc_hour;
    logic       w_tick;
    logic       w_sec_wrap;
    logic       w_min_wrap;
    logic       w_hour_wrap;
    logic       w_day;
    logic       w_time_upd;
    logic [7:0] w_sec_next;
    logic [7:0] w_min_next;
    logic [7:0] w_unused_hour_next;

    // Synchronizer chain plus one history flop; the history flop sees the
    // synchronized level so rise is a clean single-cycle strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_hist <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], tick_in};
            r_hist <= r_sync[SYNC_STAGES-1];
        end
    end

    assign w_rise = r_sync[SYNC_STAGES-1] & ~r_hist;

    assign w_load_valid = bcd_valid(set_sec, SEC_MAX) &
                          bcd_valid(set_min, MIN_MAX) &
                          bcd_valid(set_hour, HOUR_MAX);
    assign w_load_ok    = load & w_load_valid;
    assign w_load_bad   = load & ~w_load_valid;

    assign w_inc_min  = inc_min  & ~load;
    assign w_inc_hour = inc_hour & ~load;
    assign w_tick     = run & w_rise & ~load & ~inc_min & ~inc_hour;

    bcd_mod_counter u_sec (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_tick),
        .i_load     (w_load_ok),
        .i_load_val (set_sec),
        .i_max      (SEC_MAX),
        .o_value    (sec_bcd),
        .o_next     (w_sec_next),
        .o_wrap     (w_sec_wrap)
    );

    // Manual minute adjust wraps 59->00 without touching the hour, so only
    // tick-driven carries feed the hour counter.
    bcd_mod_counter u_min (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_inc_min | (w_tick & w_sec_wrap)),
        .i_load     (w_load_ok),
        .i_load_val (set_min),
        .i_max      (MIN_MAX),
        .o_value    (min_bcd),
        .o_next     (w_min_next),
        .o_wrap     (w_min_wrap)
    );

    bcd_mod_counter u_hour (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_inc      (w_inc_hour | (w_tick & w_sec_wrap & w_min_wrap)),
        .i_load     (w_load_ok),
        .i_load_val (set_hour),
        .i_max      (HOUR_MAX),
        .o_value    (hour_bcd),
        .o_next     (w_unused_hour_next),
        .o_wrap     (w_hour_wrap)
    );

    // A manual hour wrap is not a day rollover; only a tick carry counts.
    assign w_day      = w_tick & w_sec_wrap & w_min_wrap & w_hour_wrap;
    assign w_time_upd = w_tick | w_load_ok | w_inc_min | w_inc_hour;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sec_pulse <= 1'b0;
            r_day_wrap  <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_sec_pulse <= w_tick;
            r_day_wrap  <= w_day;
            r_load_err  <= w_load_bad;
        end
    end

    assign sec_pulse = r_sec_pulse;
    assign day_wrap  = r_day_wrap;
    assign load_err  = r_load_err;

`ifdef HOURLY_CHIME_EN
    logic r_chime;

    // Evaluated on the next-state time so chime changes on the same edge as
    // the displayed time, including when a load lands inside the window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chime <= 1'b0;
        end else if (w_time_upd) begin
            r_chime <= (w_min_next == 8'h00) && (w_sec_next < CHIME_BCD);
        end
    end

    assign chime = r_chime;
`else
    logic w_unused_chime;

    assign w_unused_chime = ^{CHIME_BCD, w_sec_next, w_min_next, w_time_upd};
    assign chime          = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
module tb_time_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_in;
    logic       run;
    logic       load;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic [7:0] set_sec;
    logic       inc_min;
    logic       inc_hour;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic       sec_pulse;
    logic       day_wrap;
    logic       load_err;
    logic       chime;

    time_counter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_in   (tick_in),
        .run       (run),
        .load      (load),
        .set_hour  (set_hour),
        .set_min   (set_min),
        .set_sec   (set_sec),
        .inc_min   (inc_min),
        .inc_hour  (inc_hour),
        .hour_bcd  (hour_bcd),
        .min_bcd   (min_bcd),
        .sec_bcd   (sec_bcd),
        .sec_pulse (sec_pulse),
        .day_wrap  (day_wrap),
        .load_err  (load_err),
        .chime     (chime)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Reference time in plain decimal, plus the expected chime level.
    int   mh = 0;
    int   mm = 0;
    int   ms = 0;
    logic mch = 1'b0;

    typedef struct {
        int          due;
        string       tag;
        logic [23:0] t;
        logic [3:0]  f;
    } exp_t;

    exp_t q[$];

    function automatic logic [7:0] to_bcd(int v);
        return 8'(((v / 10) << 4) | (v % 10));
    endfunction

    function automatic int dec(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic logic field_ok(logic [7:0] v, int maxdec);
        return (v[7:4] < 4'd10) && (v[3:0] < 4'd10) && (dec(v) <= maxdec);
    endfunction

    function automatic void upd_chime();
`ifdef HOURLY_CHIME_EN
        mch = (mm == 0) && (ms < 5);
`else
        mch = 1'b0;
`endif
    endfunction

    function automatic void push(int due, string tag, logic sp, logic dw, logic le);
        exp_t e;
        e.due = due;
        e.tag = tag;
        e.t   = {to_bcd(mh), to_bcd(mm), to_bcd(ms)};
        e.f   = {sp, dw, le, mch};
        q.push_back(e);
    endfunction

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: compare every expectation due this cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            exp_t e;
            e = q.pop_front();
            check({e.tag, "_time"}, 32'({hour_bcd, min_bcd, sec_bcd}), 32'(e.t));
            check({e.tag, "_flags"}, 32'({sec_pulse, day_wrap, load_err, chime}), 32'(e.f));
        end
    end

    // One full tick_in period: rise is seen two edges after the first
    // sampling edge, so the update lands three negedges after driving.
    task automatic do_tick(string tag);
        int   n;
        logic wrap;
        n       = cyc;
        tick_in = 1'b1;
        push(n + 2, {tag, "_pre"}, 1'b0, 1'b0, 1'b0);
        wrap = 1'b0;
        if (run) begin
            ms++;
            if (ms == 60) begin
                ms = 0;
                mm++;
                if (mm == 60) begin
                    mm = 0;
                    mh++;
                    if (mh == 24) begin
                        mh   = 0;
                        wrap = 1'b1;
                    end
                end
            end
            upd_chime();
        end
        push(n + 3, {tag, "_upd"}, run, wrap, 1'b0);
        push(n + 4, {tag, "_post"}, 1'b0, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_load(string tag, logic [7:0] bh, logic [7:0] bm, logic [7:0] bs);
        int   n;
        logic ok;
        n        = cyc;
        load     = 1'b1;
        set_hour = bh;
        set_min  = bm;
        set_sec  = bs;
        ok = field_ok(bh, 23) && field_ok(bm, 59) && field_ok(bs, 59);
        if (ok) begin
            mh = dec(bh);
            mm = dec(bm);
            ms = dec(bs);
            upd_chime();
        end
        push(n + 1, tag, 1'b0, 1'b0, !ok);
        @(negedge clk);
        load = 1'b0;
        push(n + 2, {tag, "_after"}, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    task automatic do_inc(string tag, logic im, logic ih);
        int n;
        n        = cyc;
        inc_min  = im;
        inc_hour = ih;
        if (im) mm = (mm + 1) % 60;
        if (ih) mh = (mh + 1) % 24;
        upd_chime();
        push(n + 1, tag, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        inc_min  = 1'b0;
        inc_hour = 1'b0;
        push(n + 2, {tag, "_after"}, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst_n    = 1'b0;
        tick_in  = 1'b0;
        run      = 1'b0;
        load     = 1'b0;
        set_hour = 8'h00;
        set_min  = 8'h00;
        set_sec  = 8'h00;
        inc_min  = 1'b0;
        inc_hour = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h0);
        check("reset_flags", 32'({sec_pulse, day_wrap, load_err, chime}), 32'h0);
        rst_n = 1'b1;
        run   = 1'b1;
        @(negedge clk);

        // Three ticks from reset.
        do_tick("t1_a");
        do_tick("t1_b");
        do_tick("t1_c");

        // Ticks ignored while stopped.
        run = 1'b0;
        do_tick("run0");
        run = 1'b1;

        // Day rollover.
        do_load("t2_load", 8'h23, 8'h59, 8'h58);
        do_tick("t2_a");
        do_tick("t2_b");

        // Load validation.
        do_load("t3_badnib", 8'h1A, 8'h00, 8'h00);
        do_load("t3_badhr", 8'h24, 8'h00, 8'h00);
        do_load("t3_badmin", 8'h12, 8'h60, 8'h00);
        do_load("t3_good", 8'h12, 8'h34, 8'h56);

        // Load coincides with the rise: the tick is dropped.
        n       = cyc;
        tick_in = 1'b1;
        push(n + 2, "t4_pre", 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        load     = 1'b1;
        set_hour = 8'h08;
        set_min  = 8'h15;
        set_sec  = 8'h30;
        mh = 8; mm = 15; ms = 30;
        upd_chime();
        push(n + 3, "t4_load", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        push(n + 4, "t4_hold", 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        tick_in = 1'b0;
        repeat (4) @(negedge clk);
        do_tick("t4_next");

        // Manual adjust.
        do_load("t5_load1", 8'h10, 8'h59, 8'h30);
        do_inc("t5_incmin", 1'b1, 1'b0);
        do_load("t5_load2", 8'h23, 8'h15, 8'h00);
        do_inc("t5_inchour", 1'b0, 1'b1);
        do_load("t5_load3", 8'h09, 8'h59, 8'h00);
        do_inc("t5_incboth", 1'b1, 1'b1);

        // Hourly chime window.
        do_load("t6_load", 8'h00, 8'h59, 8'h58);
        for (int i = 0; i < 8; i++) begin
            do_tick($sformatf("t6_%0d", i));
        end

        // Asynchronous reset mid-count.
        do_load("t7_load", 8'h05, 8'h06, 8'h07);
        do_tick("t7_tick");
        #3;
        rst_n = 1'b0;
        #1;
        mh = 0; mm = 0; ms = 0; mch = 1'b0;
        check("t7_async_time", 32'({hour_bcd, min_bcd, sec_bcd}), 32'h0);
        check("t7_async_flags", 32'({sec_pulse, day_wrap, load_err, chime}), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = cyc;
        push(n + 1, "t7_rel1", 1'b0, 1'b0, 1'b0);
        push(n + 2, "t7_rel2", 1'b0, 1'b0, 1'b0);
        push(n + 3, "t7_rel3", 1'b0, 1'b0, 1'b0);
        repeat (5) @(negedge clk);

        check("sb_drain", 32'(q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
